// File: rtl/hbm_issue_pkg.sv
// Shared types and constants for the HBM bundle issuer: FSM state encoding,
// bundle widths and the default outstanding-read credit limit.
package hbm_issue_pkg;

    localparam int CMD_W                      = 128;
    localparam int WRDATA_W                   = 1024;
    localparam int DEFAULT_MAX_RD_OUTSTANDING = 16;

    typedef enum logic [1:0] {
        ST_PASS  = 2'd0,
        ST_GAP   = 2'd1,
        ST_DRAIN = 2'd2
    } issue_state_e;

endpackage

// File: rtl/hbm_rd_credit.sv
// Outstanding-read credit tracker: counts reads issued minus data returns,
// flags a sticky underflow on a return with nothing outstanding.
module hbm_rd_credit
    import hbm_issue_pkg::*;
#(
    parameter int unsigned MAX_RD_OUTSTANDING = DEFAULT_MAX_RD_OUTSTANDING,
    parameter int unsigned RD_CNT_WIDTH       = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc_en,
    input  logic [2:0]              inc_cnt,
    input  logic                    rd_ret,
    output logic [RD_CNT_WIDTH-1:0] rd_outstanding,
    output logic                    rd_underflow,
    output logic                    credit_ok
);

    // A full bundle can add 4 reads, so headroom of 4 must remain to accept.
    localparam logic [RD_CNT_WIDTH-1:0] CREDIT_THRESH = RD_CNT_WIDTH'(MAX_RD_OUTSTANDING - 4);

    logic [RD_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                    underflow_q, underflow_d;
    logic [RD_CNT_WIDTH-1:0] inc;

    always_comb begin
        inc         = inc_en ? RD_CNT_WIDTH'(inc_cnt) : '0;
        cnt_d       = cnt_q;
        underflow_d = underflow_q;
        if (rd_ret && (cnt_q == '0) && (inc == '0)) begin
            underflow_d = 1'b1;
        end else begin
            cnt_d = cnt_q + inc - RD_CNT_WIDTH'(rd_ret);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd_outstanding = cnt_q;
    assign rd_underflow   = underflow_q;
    assign credit_ok      = (cnt_q <= CREDIT_THRESH);

endmodule

// File: rtl/hbm_bundle_issuer.sv
// Flow-control stage between command generator and HBM command FIFO.
// Optional HBM_ISSUE_STATS_EN adds saturating accept/stall counters.
//
// state    | meaning
// ST_PASS  | normal operation, bundles accepted when credits/FIFO allow
// ST_GAP   | quiet period after a channel-select bundle
// ST_DRAIN | intake stopped, waiting for reads to return
module hbm_bundle_issuer
    import hbm_issue_pkg::*;
#(
    parameter int unsigned CH_SWITCH_GAP      = 8,
    parameter int unsigned MAX_RD_OUTSTANDING = DEFAULT_MAX_RD_OUTSTANDING,
    parameter int unsigned RD_CNT_WIDTH       = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CMD_W-1:0]        in_cmd,
    input  logic [WRDATA_W-1:0]     in_wrdata,
    input  logic [2:0]              in_rd_cnt,
    input  logic                    in_sel_ch,
    input  logic                    fifo_afull,
    output logic                    fifo_wr_en,
    output logic [CMD_W-1:0]        fifo_cmd,
    output logic [WRDATA_W-1:0]     fifo_wrdata,
    input  logic                    rd_ret,
    input  logic                    drain_req,
    output logic                    drain_done,
    output logic [RD_CNT_WIDTH-1:0] rd_outstanding,
    output logic                    rd_underflow,
    output logic [31:0]             stat_bundles,
    output logic [31:0]             stat_stall_cycles
);

    localparam int GAP_W = (CH_SWITCH_GAP > 2) ? $clog2(CH_SWITCH_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((CH_SWITCH_GAP > 0) ? CH_SWITCH_GAP - 1 : 0);

    issue_state_e         state_q, state_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                 fifo_wr_en_q, fifo_wr_en_d;
    logic [CMD_W-1:0]     fifo_cmd_q, fifo_cmd_d;
    logic [WRDATA_W-1:0]  fifo_wrdata_q, fifo_wrdata_d;
    logic                 credit_ok;
    logic                 accept;

    hbm_rd_credit #(
        .MAX_RD_OUTSTANDING (MAX_RD_OUTSTANDING),
        .RD_CNT_WIDTH       (RD_CNT_WIDTH)
    ) u_rd_credit (
        .clk            (clk),
        .rst            (rst),
        .inc_en         (accept),
        .inc_cnt        (in_rd_cnt),
        .rd_ret         (rd_ret),
        .rd_outstanding (rd_outstanding),
        .rd_underflow   (rd_underflow),
        .credit_ok      (credit_ok)
    );

    always_comb begin
        in_ready      = !rst && (state_q == ST_PASS) && !fifo_afull && !drain_req && credit_ok;
        accept        = in_valid && in_ready;
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        fifo_wr_en_d  = accept;
        fifo_cmd_d    = accept ? in_cmd : fifo_cmd_q;
        fifo_wrdata_d = accept ? in_wrdata : fifo_wrdata_q;
        // accept and drain_req are mutually exclusive: in_ready masks drain_req
        case (state_q)
            ST_PASS: begin
                if (accept && in_sel_ch && (CH_SWITCH_GAP > 0)) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else if (drain_req) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = drain_req ? ST_DRAIN : ST_PASS;
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!drain_req) begin
                    state_d = ST_PASS;
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_PASS;
            gap_cnt_q     <= '0;
            fifo_wr_en_q  <= 1'b0;
            fifo_cmd_q    <= '0;
            fifo_wrdata_q <= '0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            fifo_wr_en_q  <= fifo_wr_en_d;
            fifo_cmd_q    <= fifo_cmd_d;
            fifo_wrdata_q <= fifo_wrdata_d;
        end
    end

    assign fifo_wr_en  = fifo_wr_en_q;
    assign fifo_cmd    = fifo_cmd_q;
    assign fifo_wrdata = fifo_wrdata_q;
    assign drain_done  = !rst && (state_q == ST_DRAIN) && (rd_outstanding == '0) && !fifo_wr_en_q;

`ifdef HBM_ISSUE_STATS_EN
    logic [31:0] stat_bundles_q, stat_bundles_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    always_comb begin
        stat_bundles_d = stat_bundles_q;
        stat_stall_d   = stat_stall_q;
        if (accept && (stat_bundles_q != '1)) begin
            stat_bundles_d = stat_bundles_q + 32'd1;
        end
        if (in_valid && !in_ready && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bundles_q <= '0;
            stat_stall_q   <= '0;
        end else begin
            stat_bundles_q <= stat_bundles_d;
            stat_stall_q   <= stat_stall_d;
        end
    end

    assign stat_bundles      = stat_bundles_q;
    assign stat_stall_cycles = stat_stall_q;
`else
    assign stat_bundles      = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule
